// File: rtl/bg_fade_draw.sv
// Background renderer: registered RGB332 pixel from game state with frame-synchronous
// cross-fade, border bracket and info-bar flag. Optional 32x32 play-state checker: BG_CHECKER_EN.
module bg_fade_draw #(
  parameter int          STATE_W      = 2,
  parameter int          FADE_LOG2    = 4,
  parameter int          FRAME_W      = 640,
  parameter int          FRAME_H      = 480,
  parameter int          BORDER_W     = 10,
  parameter int          INFO_H       = 32,
  parameter logic [7:0]  BORDER_COLOR = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic [STATE_W-1:0] bgState,
  input  logic [10:0]        pixelX,
  input  logic [10:0]        pixelY,
  output logic [7:0]         BG_RGB,
  output logic               infoRequest,
  output logic               fadeBusy
);

  localparam int              SW        = (FADE_LOG2 > 0) ? FADE_LOG2 : 1;
  localparam logic [SW-1:0]   LAST_STEP = SW'((1 << FADE_LOG2) - 1);
  localparam logic [7:0]      PAL0      = 8'b000_100_00;
  localparam logic [10:0]     X_MAX     = 11'(FRAME_W);
  localparam logic [10:0]     Y_MAX     = 11'(FRAME_H);
  localparam logic [10:0]     BW        = 11'(BORDER_W);
  localparam logic [10:0]     X_HI      = 11'(FRAME_W - BORDER_W);
  localparam logic [10:0]     Y_HI      = 11'(FRAME_H - BORDER_W);
  localparam logic [10:0]     INFO_Y    = 11'(INFO_H);

  typedef enum logic {IDLE, FADE} fsm_t;

  // States above 3 alias onto the four base colours.
  function automatic logic [7:0] palette(input logic [STATE_W-1:0] s);
    logic [31:0] i;
    i = 32'(s);
    unique case (i[1:0])
      2'd0: palette = 8'b000_100_00;
      2'd1: palette = 8'b100_000_00;
      2'd2: palette = 8'b000_000_10;
      2'd3: palette = 8'b001_001_01;
    endcase
  endfunction

  // Signed difference scaled by step, arithmetic shift keeps the result between endpoints.
  function automatic logic [2:0] blend_ch(input logic [2:0] f, input logic [2:0] t,
                                          input logic [SW-1:0] s);
    logic signed [15:0] d;
    logic signed [15:0] p;
    d = $signed({13'd0, t}) - $signed({13'd0, f});
    p = d * $signed({{(16 - SW){1'b0}}, s});
    p = p >>> FADE_LOG2;
    blend_ch = f + p[2:0];
  endfunction

  function automatic logic [7:0] blend(input logic [7:0] f, input logic [7:0] t,
                                       input logic [SW-1:0] s);
    logic [2:0] r, g, b;
    r = blend_ch(f[7:5], t[7:5], s);
    g = blend_ch(f[4:2], t[4:2], s);
    b = blend_ch({1'b0, f[1:0]}, {1'b0, t[1:0]}, s);
    blend = {r, g, b[1:0]};
  endfunction

  fsm_t               state, state_n;
  logic [STATE_W-1:0] cur_state, cur_n, tgt_state, tgt_n;
  logic [SW-1:0]      step, step_n;
  logic [7:0]         from_color, from_n, to_color, to_n;
  logic [7:0]         fade_color, scene_color, pix_color;
  logic               in_frame, border;

  assign fade_color  = blend(from_color, to_color, step);
  assign scene_color = (state == FADE) ? fade_color : palette(cur_state);
  assign fadeBusy    = (state == FADE);

  // NOTE: non-blocking (<=) for every register so all state updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cur_state  <= '0;
      tgt_state  <= '0;
      step       <= '0;
      from_color <= PAL0;
      to_color   <= PAL0;
    end else begin
      state      <= state_n;
      cur_state  <= cur_n;
      tgt_state  <= tgt_n;
      step       <= step_n;
      from_color <= from_n;
      to_color   <= to_n;
    end
  end

  // NOTE: every output of this block is defaulted first so no latch is inferred.
  always_comb begin
    state_n = state;
    cur_n   = cur_state;
    tgt_n   = tgt_state;
    step_n  = step;
    from_n  = from_color;
    to_n    = to_color;
    unique case (state)
      IDLE: begin
        if (bgState != cur_state) begin
          if (FADE_LOG2 > 0) begin
            from_n  = palette(cur_state);
            to_n    = palette(bgState);
            tgt_n   = bgState;
            step_n  = '0;
            state_n = FADE;
          end else begin
            cur_n = bgState;
          end
        end
      end
      FADE: begin
        // A new request restarts from the colour on screen and wins over startOfFrame.
        if (bgState != tgt_state) begin
          from_n = fade_color;
          to_n   = palette(bgState);
          tgt_n  = bgState;
          step_n = '0;
        end else if (startOfFrame) begin
          if (step == LAST_STEP) begin
            cur_n   = tgt_state;
            state_n = IDLE;
          end else begin
            step_n = step + SW'(1);
          end
        end
      end
    endcase
  end

  assign in_frame = (pixelX < X_MAX) && (pixelY < Y_MAX);
  assign border   = in_frame && ((pixelX < BW) || (pixelX >= X_HI) ||
                                 (pixelY < BW) || (pixelY >= Y_HI));

`ifdef BG_CHECKER_EN
  always_comb begin
    pix_color = scene_color;
    if (state == IDLE && cur_state == STATE_W'(1) && (pixelX[5] ^ pixelY[5]))
      pix_color = {1'b0, scene_color[7:6], 1'b0, scene_color[4:3], 1'b0, scene_color[1]};
  end
`else
  assign pix_color = scene_color;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      BG_RGB      <= 8'h00;
      infoRequest <= 1'b0;
    end else begin
      if (!in_frame)   BG_RGB <= 8'h00;
      else if (border) BG_RGB <= BORDER_COLOR;
      else             BG_RGB <= pix_color;
      infoRequest <= in_frame && !border && (pixelY < INFO_Y);
    end
  end

endmodule

// File: tb/tb_bg_fade_draw.sv
// Directed bench for bg_fade_draw: reset, fade, retarget, border, info bar, mid-fade reset.
module tb_bg_fade_draw;

  logic        clk = 1'b0;
  logic        reset;
  logic        startOfFrame;
  logic [1:0]  bgState;
  logic [10:0] pixelX, pixelY;
  logic [7:0]  BG_RGB;
  logic        infoRequest;
  logic        fadeBusy;

  int vectors     = 0;
  int miscompares = 0;

  bg_fade_draw dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .bgState      (bgState),
    .pixelX       (pixelX),
    .pixelY       (pixelY),
    .BG_RGB       (BG_RGB),
    .infoRequest  (infoRequest),
    .fadeBusy     (fadeBusy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sof_pulse(input int n);
    repeat (n) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
    end
  endtask

  task automatic pix(input string tag, input int x, input int y,
                     input logic [7:0] exp_rgb, input logic exp_info);
    pixelX = 11'(x);
    pixelY = 11'(y);
    tick();
    check({tag, "_rgb"}, BG_RGB, exp_rgb);
    check({tag, "_info"}, {7'd0, infoRequest}, {7'd0, exp_info});
  endtask

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; bgState = 2'd0;
    pixelX = 11'd100; pixelY = 11'd100;
    repeat (3) tick();
    check("rst_rgb", BG_RGB, 8'h00);
    check("rst_info", {7'd0, infoRequest}, 8'h00);
    check("rst_busy", {7'd0, fadeBusy}, 8'h00);
    reset = 1'b0;
    tick();
    check("idle0_rgb", BG_RGB, 8'h10);
    check("idle0_busy", {7'd0, fadeBusy}, 8'h00);

    // Fade 0 -> 1 over 16 frames
    bgState = 2'd1;
    tick();
    check("fade_start_busy", {7'd0, fadeBusy}, 8'h01);
    tick();
    check("fade_step0", BG_RGB, 8'h10);
    sof_pulse(1);
    check("fade_step1", BG_RGB, 8'h0C);
    sof_pulse(7);
    check("fade_step8", BG_RGB, 8'h48);
    sof_pulse(7);
    check("fade_step15", BG_RGB, 8'h60);
    check("fade_step15_busy", {7'd0, fadeBusy}, 8'h01);
    sof_pulse(1);
    check("fade_done", BG_RGB, 8'h80);
    check("fade_done_busy", {7'd0, fadeBusy}, 8'h00);

    // Retarget at step 8 to state 2, coinciding with startOfFrame
    reset = 1'b1; bgState = 2'd0;
    tick();
    reset = 1'b0;
    tick();
    check("rst2_rgb", BG_RGB, 8'h10);
    bgState = 2'd1;
    tick();
    sof_pulse(8);
    check("refade_step8", BG_RGB, 8'h48);
    bgState = 2'd2; startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
    check("retarget_from", BG_RGB, 8'h48);
    check("retarget_busy", {7'd0, fadeBusy}, 8'h01);
    sof_pulse(8);
    check("retarget_step8", BG_RGB, 8'h25);
    sof_pulse(8);
    check("retarget_done", BG_RGB, 8'h02);
    check("retarget_done_busy", {7'd0, fadeBusy}, 8'h00);

    // Border, frame edges and info bar in state 2
    pix("b_left",     0,   200, 8'hFF, 1'b0);
    pix("b_right",    639, 200, 8'hFF, 1'b0);
    pix("b_bottom",   300, 479, 8'hFF, 1'b0);
    pix("b_left_in",  9,   200, 8'hFF, 1'b0);
    pix("b_right_in", 630, 200, 8'hFF, 1'b0);
    pix("inner_r",    629, 200, 8'h02, 1'b0);
    pix("b_bot_in",   300, 470, 8'hFF, 1'b0);
    pix("inner_b",    300, 469, 8'h02, 1'b0);
    pix("corner_in",  10,  10,  8'h02, 1'b1);
    pix("outside_x",  700, 10,  8'h00, 1'b0);
    pix("outside_x0", 640, 20,  8'h00, 1'b0);
    pix("outside_y",  200, 480, 8'h00, 1'b0);
    pix("info_top",   200, 5,   8'hFF, 1'b0);
    pix("info_mid",   200, 20,  8'h02, 1'b1);
    pix("info_last",  200, 31,  8'h02, 1'b1);
    pix("info_end",   200, 32,  8'h02, 1'b0);
    pix("info_below", 200, 40,  8'h02, 1'b0);

    // Reset in the middle of a fade together with startOfFrame
    pixelX = 11'd100; pixelY = 11'd100;
    bgState = 2'd0;
    tick();
    sof_pulse(3);
    check("midfade_busy", {7'd0, fadeBusy}, 8'h01);
    reset = 1'b1; startOfFrame = 1'b1;
    tick();
    check("midrst_rgb", BG_RGB, 8'h00);
    check("midrst_busy", {7'd0, fadeBusy}, 8'h00);
    reset = 1'b0; startOfFrame = 1'b0;
    tick();
    check("postrst_rgb", BG_RGB, 8'h10);
    check("postrst_busy", {7'd0, fadeBusy}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
